// File: rtl/rv_decode_stage.sv
// RV32I decode/dispatch stage: decodes a fetched instruction into ALU operands
// plus writeback/memory/control-flow sideband, held in one handshaked register.
package rv;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_EQ, ALU_NEQ, ALU_SBT, ALU_SBTU
  } RV32_ALU_OPCODE;
endpackage

module rv_decode_stage
  import rv::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [31:0]    in_pc,
  output logic [4:0]     rs1_addr,
  output logic [4:0]     rs2_addr,
  input  logic [31:0]    rs1_data,
  input  logic [31:0]    rs2_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    alu_op1,
  output logic [31:0]    alu_op2,
  output RV32_ALU_OPCODE alu_opcode,
  output logic [31:0]    out_pc,
  output logic [4:0]     rd,
  output logic           wb_en,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [2:0]     mem_funct3,
  output logic [31:0]    store_data,
  output logic           is_branch,
  output logic           is_jump,
  output logic [31:0]    br_target,
  output logic           illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  function automatic logic signed [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // alt selects SUB for f3=000 and SRA for f3=101
  function automatic RV32_ALU_OPCODE alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       accept;

  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  logic           vld_p1;
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic signed [31:0] op1_p0, op2_p0, sd_p0, tgt_p0;
  RV32_ALU_OPCODE     opc_p0;
  logic               wb_p0, mrd_p0, mwr_p0, br_p0, jmp_p0, ill_p0;
  logic [2:0]         mf3_p0;

  always_comb begin
    op1_p0 = '0;
    op2_p0 = '0;
    sd_p0  = '0;
    tgt_p0 = '0;
    opc_p0 = ALU_ADD;
    wb_p0  = 1'b0;
    mrd_p0 = 1'b0;
    mwr_p0 = 1'b0;
    br_p0  = 1'b0;
    jmp_p0 = 1'b0;
    ill_p0 = 1'b0;
    mf3_p0 = '0;
    case (opcode)
      OPC_OP: begin
        op1_p0 = rs1_data;
        op2_p0 = rs2_data;
        wb_p0  = 1'b1;
        opc_p0 = alu_from_f3(f3, f7[5]);
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
          ill_p0 = 1'b1;
      end
      OPC_OPIMM: begin
        op1_p0 = rs1_data;
        op2_p0 = imm_i(in_instr);
        wb_p0  = 1'b1;
        opc_p0 = alu_from_f3(f3, f3 == 3'b101 && f7[5]);
        // shifts carry only the 5-bit shamt; upper imm bits select the shift type
        if (f3 == 3'b001 || f3 == 3'b101) begin
          op2_p0 = {27'b0, in_instr[24:20]};
          if (!(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20)))
            ill_p0 = 1'b1;
        end
      end
      OPC_LUI: begin
        op2_p0 = imm_u(in_instr);
        wb_p0  = 1'b1;
      end
      OPC_AUIPC: begin
        op1_p0 = in_pc;
        op2_p0 = imm_u(in_instr);
        wb_p0  = 1'b1;
      end
      OPC_JAL: begin
        op1_p0 = in_pc;
        op2_p0 = 32'd4;
        wb_p0  = 1'b1;
        jmp_p0 = 1'b1;
        tgt_p0 = in_pc + imm_j(in_instr);
      end
      OPC_JALR: begin
        op1_p0 = in_pc;
        op2_p0 = 32'd4;
        wb_p0  = 1'b1;
        jmp_p0 = 1'b1;
        tgt_p0 = (rs1_data + imm_i(in_instr)) & ~32'd1;
        if (f3 != 3'b000) ill_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        op1_p0 = rs1_data;
        op2_p0 = rs2_data;
        br_p0  = 1'b1;
        tgt_p0 = in_pc + imm_b(in_instr);
        case (f3)
          3'b000:  opc_p0 = ALU_EQ;
          3'b001:  opc_p0 = ALU_NEQ;
          3'b100:  opc_p0 = ALU_SLT;
          3'b101:  opc_p0 = ALU_SBT;
          3'b110:  opc_p0 = ALU_SLTU;
          3'b111:  opc_p0 = ALU_SBTU;
          default: ill_p0 = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        op1_p0 = rs1_data;
        op2_p0 = imm_i(in_instr);
        wb_p0  = 1'b1;
        mrd_p0 = 1'b1;
        mf3_p0 = f3;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill_p0 = 1'b1;
      end
      OPC_STORE: begin
        op1_p0 = rs1_data;
        op2_p0 = imm_s(in_instr);
        mwr_p0 = 1'b1;
        mf3_p0 = f3;
        sd_p0  = rs2_data;
        if (f3[2] || f3 == 3'b011) ill_p0 = 1'b1;
      end
      default: ill_p0 = 1'b1;
    endcase
    if (ill_p0) begin
      opc_p0 = ALU_ADD;
      wb_p0  = 1'b0;
      mrd_p0 = 1'b0;
      mwr_p0 = 1'b0;
      br_p0  = 1'b0;
      jmp_p0 = 1'b0;
    end
    if (in_instr[11:7] == 5'd0) wb_p0 = 1'b0;
  end

  // ---- stage p1: handshaked output register ----
  logic signed [31:0] op1_p1, op2_p1, sd_p1, tgt_p1, pc_p1;
  RV32_ALU_OPCODE     opc_p1;
  logic [4:0]         rd_p1;
  logic               wb_p1, mrd_p1, mwr_p1, br_p1, jmp_p1, ill_p1;
  logic [2:0]         mf3_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op1_p1 <= '0;
      op2_p1 <= '0;
      sd_p1  <= '0;
      tgt_p1 <= '0;
      pc_p1  <= RESET_PC;
      opc_p1 <= ALU_ADD;
      rd_p1  <= '0;
      wb_p1  <= 1'b0;
      mrd_p1 <= 1'b0;
      mwr_p1 <= 1'b0;
      br_p1  <= 1'b0;
      jmp_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      mf3_p1 <= '0;
    end else begin
      if (flush)         vld_p1 <= 1'b0;
      else if (accept)   vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (accept && !flush) begin
        op1_p1 <= op1_p0;
        op2_p1 <= op2_p0;
        sd_p1  <= sd_p0;
        tgt_p1 <= tgt_p0;
        pc_p1  <= in_pc;
        opc_p1 <= opc_p0;
        rd_p1  <= in_instr[11:7];
        wb_p1  <= wb_p0;
        mrd_p1 <= mrd_p0;
        mwr_p1 <= mwr_p0;
        br_p1  <= br_p0;
        jmp_p1 <= jmp_p0;
        ill_p1 <= ill_p0;
        mf3_p1 <= mf3_p0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign alu_op1    = op1_p1;
  assign alu_op2    = op2_p1;
  assign alu_opcode = opc_p1;
  assign out_pc     = pc_p1;
  assign rd         = rd_p1;
  assign wb_en      = wb_p1;
  assign mem_rd     = mrd_p1;
  assign mem_wr     = mwr_p1;
  assign mem_funct3 = mf3_p1;
  assign store_data = sd_p1;
  assign is_branch  = br_p1;
  assign is_jump    = jmp_p1;
  assign br_target  = tgt_p1;
  assign illegal    = ill_p1;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vectors, backpressure, flush and reset.
module tb_rv_decode_stage;
  import rv::*;

  localparam logic [31:0] RPC = 32'h0000_0080;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]    in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]     rs1_addr, rs2_addr, rd;
  logic [31:0]    alu_op1, alu_op2, out_pc, store_data, br_target;
  RV32_ALU_OPCODE alu_opcode;
  logic           wb_en, mem_rd, mem_wr, is_branch, is_jump, illegal;
  logic [2:0]     mem_funct3;

  int n_cmp = 0;
  int n_bad = 0;

  rv_decode_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .out_pc(out_pc), .rd(rd), .wb_en(wb_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_funct3(mem_funct3), .store_data(store_data), .is_branch(is_branch),
    .is_jump(is_jump), .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (alu_opcode !== ALU_ADD) begin n_bad++; $display("FAIL reset_opc got %0d want %0d", alu_opcode, ALU_ADD); end
    n_cmp++; if (out_pc !== RPC) begin n_bad++; $display("FAIL reset_pc got %h want %h", out_pc, RPC); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    n_cmp++; if (alu_op1 !== 32'd0 || wb_en !== 1'b0) begin n_bad++; $display("FAIL reset_data got op1=%h wb=%0b want 0/0", alu_op1, wb_en); end
    rst = 1'b0;
  endtask

  task automatic test_alu_ops;
    n_cmp++; if (rs1_addr !== 5'd0) begin n_bad++; $display("FAIL idle_rs1addr got %0d want 0", rs1_addr); end
    in_instr = 32'h002081B3; #1;
    n_cmp++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin n_bad++; $display("FAIL rs_addr got %0d/%0d want 1/2", rs1_addr, rs2_addr); end
    send(32'h002081B3, 32'h10, 32'd5, 32'd7);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %0b want 1", out_valid); end
    n_cmp++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin n_bad++; $display("FAIL add_ops got %h/%h want 5/7", alu_op1, alu_op2); end
    n_cmp++; if (alu_opcode !== ALU_ADD || rd !== 5'd3 || wb_en !== 1'b1) begin n_bad++; $display("FAIL add_ctl got opc=%0d rd=%0d wb=%0b want %0d/3/1", alu_opcode, rd, wb_en, ALU_ADD); end
    n_cmp++; if (out_pc !== 32'h10) begin n_bad++; $display("FAIL add_pc got %h want 10", out_pc); end
    send(32'h402081B3, 32'h14, 32'd5, 32'd7);
    n_cmp++; if (alu_opcode !== ALU_SUB || out_valid !== 1'b1) begin n_bad++; $display("FAIL sub_opc got %0d want %0d", alu_opcode, ALU_SUB); end
    send(32'h00208033, 32'h18, 32'd5, 32'd7);
    n_cmp++; if (wb_en !== 1'b0 || rd !== 5'd0) begin n_bad++; $display("FAIL rd0_wb got wb=%0b want 0", wb_en); end
    send(32'h622081B3, 32'h1C, 32'd5, 32'd7);
    n_cmp++; if (illegal !== 1'b1 || wb_en !== 1'b0) begin n_bad++; $display("FAIL op_badf7 got ill=%0b wb=%0b want 1/0", illegal, wb_en); end
  endtask

  task automatic test_imm;
    send(32'h4030D213, 32'h20, 32'h8000_0000, 32'd0);
    n_cmp++; if (alu_opcode !== ALU_SRA || alu_op2 !== 32'd3 || rd !== 5'd4) begin n_bad++; $display("FAIL srai got opc=%0d op2=%h rd=%0d want %0d/3/4", alu_opcode, alu_op2, rd, ALU_SRA); end
    n_cmp++; if (alu_op1 !== 32'h8000_0000 || illegal !== 1'b0) begin n_bad++; $display("FAIL srai_op1 got %h ill=%0b want 80000000/0", alu_op1, illegal); end
    send(32'h123452B7, 32'h24, 32'hDEAD_BEEF, 32'd0);
    n_cmp++; if (alu_op1 !== 32'd0 || alu_op2 !== 32'h1234_5000) begin n_bad++; $display("FAIL lui_ops got %h/%h want 0/12345000", alu_op1, alu_op2); end
    n_cmp++; if (alu_opcode !== ALU_ADD || rd !== 5'd5 || wb_en !== 1'b1) begin n_bad++; $display("FAIL lui_ctl got opc=%0d rd=%0d wb=%0b want %0d/5/1", alu_opcode, rd, wb_en, ALU_ADD); end
    send(32'h0020A423, 32'h28, 32'h1000, 32'hCAFE_F00D);
    n_cmp++; if (mem_wr !== 1'b1 || wb_en !== 1'b0 || store_data !== 32'hCAFE_F00D || alu_op2 !== 32'd8 || mem_funct3 !== 3'b010) begin n_bad++; $display("FAIL sw got wr=%0b wb=%0b sd=%h op2=%h f3=%0d want 1/0/cafef00d/8/2", mem_wr, wb_en, store_data, alu_op2, mem_funct3); end
  endtask

  task automatic test_branch;
    send(32'h00208463, 32'h100, 32'd9, 32'd9);
    n_cmp++; if (alu_opcode !== ALU_EQ || is_branch !== 1'b1 || wb_en !== 1'b0) begin n_bad++; $display("FAIL beq_ctl got opc=%0d br=%0b wb=%0b want %0d/1/0", alu_opcode, is_branch, wb_en, ALU_EQ); end
    n_cmp++; if (br_target !== 32'h108) begin n_bad++; $display("FAIL beq_target got %h want 108", br_target); end
    send(32'h0020A463, 32'h100, 32'd9, 32'd9);
    n_cmp++; if (illegal !== 1'b1 || is_branch !== 1'b0 || alu_opcode !== ALU_ADD || out_valid !== 1'b1) begin n_bad++; $display("FAIL br_illegal got ill=%0b br=%0b opc=%0d v=%0b want 1/0/%0d/1", illegal, is_branch, alu_opcode, out_valid, ALU_ADD); end
    send(32'h010000EF, 32'h200, 32'd0, 32'd0);
    n_cmp++; if (is_jump !== 1'b1 || br_target !== 32'h210 || alu_op1 !== 32'h200 || alu_op2 !== 32'd4 || wb_en !== 1'b1) begin n_bad++; $display("FAIL jal got j=%0b tgt=%h op1=%h op2=%h wb=%0b want 1/210/200/4/1", is_jump, br_target, alu_op1, alu_op2, wb_en); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300, 32'd5, 32'd7);
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h304; rs1_data = 32'd1; rs2_data = 32'd2;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_ready c%0d got rdy=%0b v=%0b want 0/1", c, in_ready, out_valid); end
      n_cmp++; if (out_pc !== 32'h300 || alu_opcode !== ALU_ADD || alu_op1 !== 32'd5) begin n_bad++; $display("FAIL bp_stable c%0d got pc=%h opc=%0d op1=%h want 300/%0d/5", c, out_pc, alu_opcode, alu_op1, ALU_ADD); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || alu_opcode !== ALU_SUB || alu_op1 !== 32'd1) begin n_bad++; $display("FAIL b2b got v=%0b pc=%h opc=%0d op1=%h want 1/304/%0d/1", out_valid, out_pc, alu_opcode, alu_op1, ALU_SUB); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush;
    flush = 1'b1;
    send(32'h002081B3, 32'h400, 32'd5, 32'd7);
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept got %0b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, 32'd5, 32'd7);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_held got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(32'h123452B7, 32'h600, 32'd0, 32'd0);
    in_valid = 1'b1; in_instr = 32'h002081B3;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h600) begin n_bad++; $display("FAIL pre_rst got v=%0b pc=%h want 1/600", out_valid, out_pc); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== RPC || alu_opcode !== ALU_ADD || alu_op2 !== 32'd0) begin n_bad++; $display("FAIL mid_rst got v=%0b pc=%h opc=%0d op2=%h want 0/%h/%0d/0", out_valid, out_pc, alu_opcode, alu_op2, RPC, ALU_ADD); end
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_imm;
    test_branch;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I decode/dispatch stage between fetch and execute.
- Takes a fetched instruction word, its PC and register-file read data.
- Produces the ALU operand pair and `RV32_ALU_OPCODE` (from package `rv`), plus writeback, memory and control-flow sideband.
- Single pipeline register with valid/ready handshake on both sides and a synchronous flush.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on out_pc while reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rs1_addr  out  5  combinational, in_instr[19:15]
- rs2_addr  out  5  combinational, in_instr[24:20]
- rs1_data  in  32  regfile read data for rs1_addr, valid same cycle
- rs2_data  in  32  regfile read data for rs2_addr, valid same cycle
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- alu_op1  out  32  ALU operand 1
- alu_op2  out  32  ALU operand 2
- alu_opcode  out  RV32_ALU_OPCODE  ALU operation
- out_pc  out  32  PC of held instruction
- rd  out  5  destination register
- wb_en  out  1  write ALU/load result to rd
- mem_rd, mem_wr  out  1 each  load/store
- mem_funct3  out  3  access size/sign
- store_data  out  32  rs2_data for stores
- is_branch, is_jump  out  1 each  control-flow type
- br_target  out  32  branch/jump target
- illegal  out  1  unrecognised encoding

Behaviour:
- Handshake and pipeline register:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready. All outputs register on accept; latency is 1 cycle.
  - out_valid holds with stable outputs while out_ready=0.
  - Set out_valid=1 on accept. Clear it when out_ready=1 with no accept. Accept and consume in the same cycle keeps out_valid=1 with the new bundle.
- Reset: out_valid=0, all data outputs 0, alu_opcode=ALU_ADD, out_pc=RESET_PC.
- Flush: next cycle out_valid=0. Flush overrides a simultaneous accept, so the incoming instruction is dropped. Data outputs may keep stale values. Reset has priority over flush.
- Decode (opcode = instr[6:0], f3 = [14:12], f7 = [31:25]):
  - OP 0110011: op1=rs1, op2=rs2.
    - f3 000: f7 00 → ADD, f7 20 → SUB.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by f7, 110 OR, 111 AND.
    - Any other f7 → illegal.
  - OP-IMM 0010011: op2=sign-extended I-imm, same f3 map (no SUB).
    - SLLI requires f7=00.
    - SRLI/SRAI require f7=00 / 20.
  - LUI: op1=0, op2={imm[31:12],12'b0}, ADD.
  - AUIPC: op1=pc, op2=U-imm, ADD.
  - JAL: op1=pc, op2=4, ADD, is_jump=1, br_target=pc+J-imm.
  - JALR (f3=000): op1=pc, op2=4, ADD, is_jump=1, br_target=(rs1+I-imm)&~1.
  - BRANCH: op1=rs1, op2=rs2, is_branch=1, wb_en=0, br_target=pc+B-imm.
    - f3 000 ALU_EQ, 001 ALU_NEQ, 100 ALU_SLT, 101 ALU_SBT, 110 ALU_SLTU, 111 ALU_SBTU.
    - f3 010/011 → illegal.
  - LOAD (f3 000,001,010,100,101): ADD rs1+I-imm, mem_rd=1.
  - STORE (f3 000–010): ADD rs1+S-imm, mem_wr=1, wb_en=0, store_data=rs2.
  - Anything else: illegal=1.
- An illegal instruction also forces wb_en=0, mem_rd=mem_wr=is_branch=is_jump=0, alu_opcode=ALU_ADD; it still handshakes normally.
- wb_en=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, except when rd==0, which forces wb_en=0.
- All immediate and target arithmetic is modulo 2^32; no overflow flag.

Test Plan:
- Reset; hold rst 2 cycles → out_valid=0, alu_opcode=ALU_ADD, out_pc=RESET_PC, in_ready=1.
- ADD: instr 0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op1=5, op2=7, ALU_ADD, rd=3, wb_en=1.
  - Same with 0x402081B3 → ALU_SUB.
- SRAI and LUI:
  - 0x4030D213, rs1=0x8000_0000 → ALU_SRA, op2=3, rd=4.
  - 0x123452B7 → op1=0, op2=0x1234_5000, ALU_ADD, rd=5.
- BEQ: 0x00208463 at pc=0x100 → ALU_EQ, is_branch=1, wb_en=0, br_target=0x108.
  - f3 changed to 010 → illegal=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, no second capture. Raise out_ready → back-to-back accept and consume keeps out_valid=1 with new bundle.
- Flush: flush=1 coincident with accept → next cycle out_valid=0, no bundle emitted.
  - rst=1 mid-backpressure → out_valid=0 next cycle.
